// File: rtl/multicycle_ctrl_v2.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_v2
//   Control unit for a multicycle RV32I datapath. It sequences fetch, decode,
//   execute, memory and writeback, and drives the datapath enables and mux
//   selects. Memory accesses in FETCH, MEM_RD and MEM_WR wait for mem_ready,
//   and a wait timeout traps. Illegal opcodes also trap. A trap halts the
//   controller until reset.
//
//   Outputs are decoded from the state register. Three outputs also depend on
//   an input in the same cycle: the FETCH loads and the MEM_WR retire pulse
//   need mem_ready, and the branch PC load needs branch_taken.
//
// Parameters
//   MEM_WAIT_EN  1: memory states wait for mem_ready; 0: single-cycle access
//   MAX_WAIT     wait cycles allowed in one memory state (1..255)
//   CNT_W        wait counter width, 2**CNT_W > MAX_WAIT
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   opcode            instr[6:0], sampled in DECODE
//   branch_taken      comparator result, sampled in EX_BRANCH
//   mem_ready         memory finished the current access this cycle
//   pc_load, ir_load, rf_load, mem_re, mem_we, alu_out_load   datapath enables
//   ula_op            00 add, 01 sub/compare, 10 R-type funct, 11 I-type funct
//   alu_src_a         0 rs1, 1 PC
//   alu_src_b         0 rs2, 1 immediate
//   wb_sel            0 ALU reg, 1 mem data, 2 PC+4 (link), 3 immediate
//   addr_sel          0 PC, 1 ALU result reg
//   sel_jal, sel_jalr PC target selects for JAL / JALR
//   instr_done        one-cycle retire pulse
//   trap, trap_cause  halted flag; 0 none, 1 illegal opcode, 2 memory timeout
// -----------------------------------------------------------------------------
module multicycle_ctrl_v2 #(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int MAX_WAIT    = 15,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       pc_load,
  output logic       ir_load,
  output logic       rf_load,
  output logic       mem_re,
  output logic       mem_we,
  output logic       alu_out_load,
  output logic [1:0] ula_op,
  output logic       alu_src_a,
  output logic       alu_src_b,
  output logic [1:0] wb_sel,
  output logic       addr_sel,
  output logic       sel_jal,
  output logic       sel_jalr,
  output logic       instr_done,
  output logic       trap,
  output logic [1:0] trap_cause
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  typedef enum logic [4:0] {
    S_INIT, S_FETCH, S_DECODE,
    S_EX_R, S_EX_ADDI, S_EX_LOAD, S_EX_STORE,
    S_MEM_RD, S_MEM_WR,
    S_EX_BRANCH, S_EX_JAL, S_EX_JALR, S_EX_AUIPC,
    S_WB_REG, S_WB_MEM, S_WB_LINK, S_WB_LUI,
    S_TRAP
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       cause_next;
  logic             in_mem;
  logic             mem_done;
  logic             timeout;

  assign in_mem   = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  // With waiting disabled every access completes at once, so the counter
  // never advances and a timeout can never fire.
  assign mem_done = !MEM_WAIT_EN || mem_ready;
  // Success wins over timeout: a ready on the last allowed cycle completes.
  assign timeout  = MEM_WAIT_EN && !mem_ready && (wait_cnt == MAX_CNT);

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next   = state;
    cause_next   = trap_cause;
    pc_load      = 1'b0;
    ir_load      = 1'b0;
    rf_load      = 1'b0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    alu_out_load = 1'b0;
    ula_op       = 2'b00;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    wb_sel       = 2'd0;
    addr_sel     = 1'b0;
    sel_jal      = 1'b0;
    sel_jalr     = 1'b0;
    instr_done   = 1'b0;
    trap         = 1'b0;

    unique case (state)
      S_INIT: state_next = S_FETCH;

      S_FETCH: begin
        mem_re = 1'b1;
        if (mem_done) begin
          ir_load    = 1'b1;
          pc_load    = 1'b1;               // PC <= PC+4
          state_next = S_DECODE;
        end else if (timeout) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end

      S_DECODE: begin
        unique case (opcode)
          OP_R:     state_next = S_EX_R;
          OP_LOAD:  state_next = S_EX_LOAD;
          OP_ADDI:  state_next = S_EX_ADDI;
          OP_STORE: state_next = S_EX_STORE;
          OP_BR:    state_next = S_EX_BRANCH;
          OP_JALR:  state_next = S_EX_JALR;
          OP_JAL:   state_next = S_EX_JAL;
          OP_AUIPC: state_next = S_EX_AUIPC;
          OP_LUI:   state_next = S_WB_LUI;
          default: begin
            state_next = S_TRAP;
            cause_next = CAUSE_ILLEGAL;
          end
        endcase
      end

      S_EX_R: begin
        ula_op       = 2'b10;
        alu_out_load = 1'b1;
        state_next   = S_WB_REG;
      end

      S_EX_ADDI: begin
        ula_op       = 2'b11;
        alu_src_b    = 1'b1;
        alu_out_load = 1'b1;
        state_next   = S_WB_REG;
      end

      // Loads and stores share the address computation rs1 + imm.
      S_EX_LOAD, S_EX_STORE: begin
        alu_src_b    = 1'b1;
        alu_out_load = 1'b1;
        state_next   = (state == S_EX_LOAD) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        mem_re   = 1'b1;
        addr_sel = 1'b1;
        if (mem_done) begin
          state_next = S_WB_MEM;
        end else if (timeout) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end

      S_MEM_WR: begin
        mem_we   = 1'b1;
        addr_sel = 1'b1;
        if (mem_done) begin
          instr_done = 1'b1;
          state_next = S_FETCH;
        end else if (timeout) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end

      S_EX_BRANCH: begin
        ula_op     = 2'b01;
        pc_load    = branch_taken;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end

      // The datapath link register captures PC+4 before this PC update.
      S_EX_JAL: begin
        sel_jal    = 1'b1;
        pc_load    = 1'b1;
        alu_src_a  = 1'b1;
        state_next = S_WB_LINK;
      end

      S_EX_JALR: begin
        sel_jalr   = 1'b1;
        pc_load    = 1'b1;
        alu_src_b  = 1'b1;
        state_next = S_WB_LINK;
      end

      S_EX_AUIPC: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 1'b1;
        alu_out_load = 1'b1;
        state_next   = S_WB_REG;
      end

      S_WB_REG, S_WB_MEM, S_WB_LINK, S_WB_LUI: begin
        rf_load    = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
        unique case (state)
          S_WB_MEM:  wb_sel = 2'd1;
          S_WB_LINK: wb_sel = 2'd2;
          S_WB_LUI:  wb_sel = 2'd3;
          default:   wb_sel = 2'd0;
        endcase
      end

      S_TRAP: trap = 1'b1;                 // absorbing; only reset leaves

      default: state_next = S_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_INIT;
      wait_cnt   <= '0;
      trap_cause <= 2'd0;
    end else begin
      state      <= state_next;
      trap_cause <= cause_next;
      // Any state change clears the counter, which covers entry into FETCH,
      // MEM_RD and MEM_WR; staying in a memory state means still waiting.
      if (state_next != state) begin
        wait_cnt <= '0;
      end else if (in_mem) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_v2.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl_v2
//   Self-checking bench for multicycle_ctrl_v2. Two instances share stimulus:
//   one waits for mem_ready (MAX_WAIT=15), one has waiting disabled. The
//   reference model describes each instruction as a list of steps from its
//   opcode, with the outputs each step must show; memory steps repeat until
//   the bench raises mem_ready.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl_v2;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       branch_taken;
  logic       mem_ready;

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_load;
    logic       ir_load;
    logic       rf_load;
    logic       mem_re;
    logic       mem_we;
    logic       alu_out_load;
    logic [1:0] ula_op;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [1:0] wb_sel;
    logic       addr_sel;
    logic       sel_jal;
    logic       sel_jalr;
    logic       instr_done;
    logic       trap;
    logic [1:0] trap_cause;
  } outs_t;

  // waiting instance
  logic w_pc_load, w_ir_load, w_rf_load, w_mem_re, w_mem_we, w_alu_out_load;
  logic w_alu_src_a, w_alu_src_b, w_addr_sel, w_sel_jal, w_sel_jalr, w_instr_done, w_trap;
  logic [1:0] w_ula_op, w_wb_sel, w_trap_cause;
  // no-wait instance
  logic n_pc_load, n_ir_load, n_rf_load, n_mem_re, n_mem_we, n_alu_out_load;
  logic n_alu_src_a, n_alu_src_b, n_addr_sel, n_sel_jal, n_sel_jalr, n_instr_done, n_trap;
  logic [1:0] n_ula_op, n_wb_sel, n_trap_cause;

  outs_t obs_w, obs_n;
  assign obs_w = {w_pc_load, w_ir_load, w_rf_load, w_mem_re, w_mem_we, w_alu_out_load,
                  w_ula_op, w_alu_src_a, w_alu_src_b, w_wb_sel, w_addr_sel, w_sel_jal,
                  w_sel_jalr, w_instr_done, w_trap, w_trap_cause};
  assign obs_n = {n_pc_load, n_ir_load, n_rf_load, n_mem_re, n_mem_we, n_alu_out_load,
                  n_ula_op, n_alu_src_a, n_alu_src_b, n_wb_sel, n_addr_sel, n_sel_jal,
                  n_sel_jalr, n_instr_done, n_trap, n_trap_cause};

  multicycle_ctrl_v2 #(.MEM_WAIT_EN(1'b1), .MAX_WAIT(15), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .pc_load(w_pc_load), .ir_load(w_ir_load),
    .rf_load(w_rf_load), .mem_re(w_mem_re), .mem_we(w_mem_we),
    .alu_out_load(w_alu_out_load), .ula_op(w_ula_op), .alu_src_a(w_alu_src_a),
    .alu_src_b(w_alu_src_b), .wb_sel(w_wb_sel), .addr_sel(w_addr_sel),
    .sel_jal(w_sel_jal), .sel_jalr(w_sel_jalr), .instr_done(w_instr_done),
    .trap(w_trap), .trap_cause(w_trap_cause)
  );

  multicycle_ctrl_v2 #(.MEM_WAIT_EN(1'b0), .MAX_WAIT(15), .CNT_W(8)) dut_nw (
    .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .pc_load(n_pc_load), .ir_load(n_ir_load),
    .rf_load(n_rf_load), .mem_re(n_mem_re), .mem_we(n_mem_we),
    .alu_out_load(n_alu_out_load), .ula_op(n_ula_op), .alu_src_a(n_alu_src_a),
    .alu_src_b(n_alu_src_b), .wb_sel(n_wb_sel), .addr_sel(n_addr_sel),
    .sel_jal(n_sel_jal), .sel_jalr(n_sel_jalr), .instr_done(n_instr_done),
    .trap(n_trap), .trap_cause(n_trap_cause)
  );

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  int total = 0;
  int bad   = 0;

  // ---------------------------------------------------------------- model
  typedef enum {
    ST_FETCH, ST_DECODE, ST_EXR, ST_EXI, ST_EXLS, ST_MRD, ST_MWR, ST_BR,
    ST_JAL, ST_JALR, ST_AUIPC, ST_WREG, ST_WMEM, ST_WLINK, ST_WLUI, ST_TRAP
  } step_t;

  step_t plan[$];

  // Step list of one instruction, from fetch to retirement.
  function automatic void build_plan(input logic [6:0] op);
    plan.delete();
    plan.push_back(ST_FETCH);
    plan.push_back(ST_DECODE);
    case (op)
      OP_R:     begin plan.push_back(ST_EXR);   plan.push_back(ST_WREG);  end
      OP_ADDI:  begin plan.push_back(ST_EXI);   plan.push_back(ST_WREG);  end
      OP_LOAD:  begin plan.push_back(ST_EXLS);  plan.push_back(ST_MRD); plan.push_back(ST_WMEM); end
      OP_STORE: begin plan.push_back(ST_EXLS);  plan.push_back(ST_MWR);   end
      OP_BR:    plan.push_back(ST_BR);
      OP_JAL:   begin plan.push_back(ST_JAL);   plan.push_back(ST_WLINK); end
      OP_JALR:  begin plan.push_back(ST_JALR);  plan.push_back(ST_WLINK); end
      OP_AUIPC: begin plan.push_back(ST_AUIPC); plan.push_back(ST_WREG);  end
      OP_LUI:   plan.push_back(ST_WLUI);
      default:  plan.push_back(ST_TRAP);
    endcase
  endfunction

  // Outputs required in one cycle of a step.
  function automatic outs_t expect_outs(input step_t s, input logic done,
                                        input logic bt, input logic [1:0] cause);
    outs_t e;
    e = '0;
    case (s)
      ST_FETCH:  begin e.mem_re = 1'b1; e.ir_load = done; e.pc_load = done; end
      ST_EXR:    begin e.ula_op = 2'b10; e.alu_out_load = 1'b1; end
      ST_EXI:    begin e.ula_op = 2'b11; e.alu_src_b = 1'b1; e.alu_out_load = 1'b1; end
      ST_EXLS:   begin e.alu_src_b = 1'b1; e.alu_out_load = 1'b1; end
      ST_MRD:    begin e.mem_re = 1'b1; e.addr_sel = 1'b1; end
      ST_MWR:    begin e.mem_we = 1'b1; e.addr_sel = 1'b1; e.instr_done = done; end
      ST_BR:     begin e.ula_op = 2'b01; e.pc_load = bt; e.instr_done = 1'b1; end
      ST_JAL:    begin e.sel_jal = 1'b1; e.pc_load = 1'b1; e.alu_src_a = 1'b1; end
      ST_JALR:   begin e.sel_jalr = 1'b1; e.pc_load = 1'b1; e.alu_src_b = 1'b1; end
      ST_AUIPC:  begin e.alu_src_a = 1'b1; e.alu_src_b = 1'b1; e.alu_out_load = 1'b1; end
      ST_WREG:   begin e.rf_load = 1'b1; e.instr_done = 1'b1; e.wb_sel = 2'd0; end
      ST_WMEM:   begin e.rf_load = 1'b1; e.instr_done = 1'b1; e.wb_sel = 2'd1; end
      ST_WLINK:  begin e.rf_load = 1'b1; e.instr_done = 1'b1; e.wb_sel = 2'd2; end
      ST_WLUI:   begin e.rf_load = 1'b1; e.instr_done = 1'b1; e.wb_sel = 2'd3; end
      ST_TRAP:   begin e.trap = 1'b1; e.trap_cause = cause; end
      default:   e = '0;
    endcase
    return e;
  endfunction

  function automatic logic [6:0] pick_op();
    case ($urandom_range(0, 8))
      0: return OP_R;     1: return OP_LOAD; 2: return OP_ADDI;
      3: return OP_STORE; 4: return OP_BR;   5: return OP_JALR;
      6: return OP_JAL;   7: return OP_AUIPC;
      default: return OP_LUI;
    endcase
  endfunction

  function automatic bit is_mem_step(input step_t s);
    return (s == ST_FETCH) || (s == ST_MRD) || (s == ST_MWR);
  endfunction

  // ---------------------------------------------------------------- driver
  // Runs one instruction. fetch_waits / mem_waits give the not-ready cycles
  // before mem_ready in FETCH and in the data access (-1: random 0..4). With
  // nw set, the no-wait instance is observed and mem_ready is held low.
  // done_cyc returns the cycle (from 1) in which instr_done was first seen.
  task automatic run_instr(input logic [6:0] op, input int fetch_waits,
                           input int mem_waits, input logic bt, input bit nw,
                           input string tag, output int done_cyc);
    int    cyc;
    int    n;
    step_t s;
    outs_t got, exp;
    cyc      = 0;
    done_cyc = -1;
    build_plan(op);
    foreach (plan[i]) begin
      s = plan[i];
      n = 0;
      if (is_mem_step(s) && !nw) begin
        n = (s == ST_FETCH) ? fetch_waits : mem_waits;
        if (n < 0) n = $urandom_range(0, 4);
      end
      for (int w = 0; w <= n; w++) begin
        @(negedge clk);
        opcode       = (s == ST_DECODE) ? op : 7'($urandom);
        branch_taken = (s == ST_BR) ? bt : 1'($urandom);
        mem_ready    = is_mem_step(s) ? (!nw && (w == n)) : 1'($urandom);
        #1;
        cyc++;
        exp = expect_outs(s, nw || (w == n), bt, 2'd0);
        got = nw ? obs_n : obs_w;
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL %s cycle %0d step %s: got %h, want %h",
                   tag, cyc, s.name(), got, exp);
        end
        if (got.instr_done && done_cyc < 0) done_cyc = cyc;
      end
    end
  endtask

  // Pulse reset; on return the instances are in the INIT cycle.
  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    reset        = 1'b1;
    mem_ready    = 1'b1;
    branch_taken = 1'b1;
    opcode       = OP_R;
    #3;
    total++;
    if (obs_w !== '0 || obs_n !== '0) begin
      bad++;
      $display("FAIL reset_hold: got %h/%h, want 0", obs_w, obs_n);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (obs_w !== '0 || obs_n !== '0) begin
      bad++;
      $display("FAIL reset_init: got %h/%h, want 0", obs_w, obs_n);
    end
  endtask

  task automatic test_latency();
    int dc;
    do_reset();
    run_instr(OP_R, 0, 0, 1'b0, 1'b0, "rtype", dc);
    total++;
    if (dc !== 4) begin bad++; $display("FAIL rtype_latency: got %0d, want 4", dc); end
    run_instr(OP_LOAD, 0, 3, 1'b0, 1'b0, "load_wait3", dc);
    total++;
    if (dc !== 8) begin bad++; $display("FAIL load_latency: got %0d, want 8", dc); end
    run_instr(OP_LUI, 0, 0, 1'b0, 1'b0, "lui", dc);
    total++;
    if (dc !== 3) begin bad++; $display("FAIL lui_latency: got %0d, want 3", dc); end
    run_instr(OP_STORE, 0, 0, 1'b0, 1'b0, "store", dc);
    total++;
    if (dc !== 4) begin bad++; $display("FAIL store_latency: got %0d, want 4", dc); end
  endtask

  task automatic test_branch();
    int dc;
    run_instr(OP_BR, 0, 0, 1'b0, 1'b0, "branch_nt", dc);
    total++;
    if (dc !== 3) begin bad++; $display("FAIL branch_nt_latency: got %0d, want 3", dc); end
    run_instr(OP_BR, 0, 0, 1'b1, 1'b0, "branch_t", dc);
    total++;
    if (dc !== 3) begin bad++; $display("FAIL branch_t_latency: got %0d, want 3", dc); end
  endtask

  task automatic test_timeout();
    step_t seq[$];
    logic  rdy[$];
    outs_t got, exp;
    int    mw;
    int    dc;
    do_reset();
    seq = {ST_FETCH, ST_DECODE, ST_EXLS};
    rdy = {1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 16; i++) begin seq.push_back(ST_MWR);  rdy.push_back(1'b0); end
    for (int i = 0; i < 5;  i++) begin seq.push_back(ST_TRAP); rdy.push_back(1'b0); end
    mw = 0;
    foreach (seq[i]) begin
      @(negedge clk);
      opcode       = (seq[i] == ST_DECODE) ? OP_STORE : 7'($urandom);
      branch_taken = 1'($urandom);
      mem_ready    = is_mem_step(seq[i]) ? rdy[i] : 1'($urandom);
      #1;
      exp = expect_outs(seq[i], rdy[i], 1'b0, (seq[i] == ST_TRAP) ? 2'd2 : 2'd0);
      total++;
      if (obs_w !== exp) begin
        bad++;
        $display("FAIL store_timeout cycle %0d step %s: got %h, want %h",
                 i + 1, seq[i].name(), obs_w, exp);
      end
      if (obs_w.mem_we) mw++;
    end
    total++;
    if (mw !== 16) begin bad++; $display("FAIL timeout_mem_we_cycles: got %0d, want 16", mw); end
    // Ready arriving in the last allowed wait cycle still completes.
    do_reset();
    run_instr(OP_STORE, 0, 15, 1'b0, 1'b0, "store_wait15", dc);
    total++;
    if (dc !== 19) begin bad++; $display("FAIL store_wait15_latency: got %0d, want 19", dc); end
    run_instr(OP_LOAD, 15, 15, 1'b0, 1'b0, "load_wait15", dc);
    total++;
    if (dc !== 35) begin bad++; $display("FAIL load_wait15_latency: got %0d, want 35", dc); end
  endtask

  task automatic test_illegal();
    step_t seq[$];
    outs_t exp;
    do_reset();
    seq = {ST_FETCH, ST_DECODE, ST_TRAP, ST_TRAP, ST_TRAP, ST_TRAP};
    foreach (seq[i]) begin
      @(negedge clk);
      opcode       = (seq[i] == ST_DECODE) ? OP_BAD : 7'($urandom);
      branch_taken = 1'($urandom);
      mem_ready    = (seq[i] == ST_FETCH) ? 1'b1 : 1'($urandom);
      #1;
      exp = expect_outs(seq[i], 1'b1, 1'b0, (seq[i] == ST_TRAP) ? 2'd1 : 2'd0);
      total++;
      if (obs_w !== exp) begin
        bad++;
        $display("FAIL illegal cycle %0d step %s: got %h, want %h",
                 i + 1, seq[i].name(), obs_w, exp);
      end
    end
    // Asynchronous reset between clock edges clears everything immediately.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if (obs_w !== '0) begin bad++; $display("FAIL trap_async_reset: got %h, want 0", obs_w); end
  endtask

  task automatic test_abort();
    step_t seq[$];
    outs_t exp;
    do_reset();
    seq = {ST_FETCH, ST_DECODE, ST_EXR, ST_WREG};
    foreach (seq[i]) begin
      @(negedge clk);
      opcode    = (seq[i] == ST_DECODE) ? OP_R : 7'($urandom);
      mem_ready = 1'b1;
      #1;
      exp = expect_outs(seq[i], 1'b1, 1'b0, 2'd0);
      total++;
      if (obs_w !== exp) begin
        bad++;
        $display("FAIL abort_setup cycle %0d: got %h, want %h", i + 1, obs_w, exp);
      end
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (obs_w !== '0) begin bad++; $display("FAIL abort_writeback: got %h, want 0", obs_w); end
  endtask

  task automatic test_nowait();
    int dc;
    do_reset();
    run_instr(OP_JAL, 0, 0, 1'b0, 1'b1, "jal_nowait", dc);
    total++;
    if (dc !== 4) begin bad++; $display("FAIL jal_nowait_latency: got %0d, want 4", dc); end
    run_instr(OP_LOAD, 0, 0, 1'b0, 1'b1, "load_nowait", dc);
    total++;
    if (dc !== 5) begin bad++; $display("FAIL load_nowait_latency: got %0d, want 5", dc); end
    run_instr(OP_STORE, 0, 0, 1'b0, 1'b1, "store_nowait", dc);
    total++;
    if (dc !== 4) begin bad++; $display("FAIL store_nowait_latency: got %0d, want 4", dc); end
  endtask

  task automatic test_back_to_back();
    int         dc;
    logic [6:0] op;
    do_reset();
    for (int k = 0; k < 60; k++) begin
      op = pick_op();
      run_instr(op, -1, -1, 1'($urandom), 1'b0, "random", dc);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_branch();
    test_timeout();
    test_illegal();
    test_abort();
    test_nowait();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
